// File: rtl/xseg_driver_if.sv
// Bus-side signals of the seven-segment driver: the select/write strobe with
// its data word, and the busy flag the host checks before writing.
interface xseg_driver_if;
    logic        sel;
    logic        we;
    logic [10:0] data_in;
    logic        busy;

    modport master (
        output sel,
        output we,
        output data_in,
        input  busy
    );

    modport slave (
        input  sel,
        input  we,
        input  data_in,
        output busy
    );
endinterface

// File: rtl/xseg_driver.sv
// Four-digit multiplexed seven-segment driver.
// A written word is turned into BCD one bit per cycle using shift-add-3. The
// result is then decoded into segment patterns that are held in digit
// registers. Scanning is free-running and never restarted by an update.
module xseg_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    xseg_driver_if.slave       bus,
    output logic [3:0]         disp_select,
    output logic [7:0]         disp_value
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_P     = 8'h8C;

    localparam logic [1:0] MODE_NUM  = 2'b00;
    localparam logic [1:0] MODE_OP   = 2'b01;
    localparam logic [1:0] MODE_DASH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj;
    logic        sign_q;
    logic [1:0]  mode_q;
    logic        show_pending_q;
    logic        busy;
    logic        accept;
    logic        conv_step;
    logic        load_en;

    logic [7:0]  dig_q [4];
    logic [7:0]  dig_d [4];

    logic [CNT_W-1:0] refresh_cnt_q;
    logic [1:0]       scan_idx_q;

    // Active-low segment pattern for one decimal digit; dp stays dark.
    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Busy covers the conversion, the load, and the one cycle in which the
    // new digits reach disp_value, so the host never sees a stale display
    // after busy drops.
    assign busy     = (state_q != IDLE) || show_pending_q;
    assign bus.busy = busy;
    assign bcd_adj  = bcd_adjust(bcd_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-state strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        conv_step = 1'b0;
        load_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sel && bus.we && !busy) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                conv_step = 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion bit counter and the post-load display flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q      <= 3'd0;
            show_pending_q <= 1'b0;
        end else begin
            show_pending_q <= load_en;
            if (accept) begin
                bit_cnt_q <= 3'd0;
            end else if (conv_step) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // Conversion datapath: capture the word, then shift-add-3 one bit per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_q  <= bus.data_in[7:0];
            bcd_q  <= 12'd0;
            sign_q <= bus.data_in[8];
            mode_q <= bus.data_in[10:9];
        end else if (conv_step) begin
            {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
        end
    end

    // Segment patterns that LOAD will commit, decoded from the BCD result.
    always_comb begin
        dig_d[0] = SEG_BLANK;
        dig_d[1] = SEG_BLANK;
        dig_d[2] = SEG_BLANK;
        dig_d[3] = SEG_BLANK;
        case (mode_q)
            MODE_NUM: begin
                dig_d[3] = (sign_q && (bcd_q != 12'd0)) ? SEG_DASH : SEG_BLANK;
                dig_d[2] = (bcd_q[11:8] != 4'd0) ? seg_digit(bcd_q[11:8]) : SEG_BLANK;
                dig_d[1] = (bcd_q[11:4] != 8'd0) ? seg_digit(bcd_q[7:4]) : SEG_BLANK;
                dig_d[0] = seg_digit(bcd_q[3:0]);
            end
            MODE_OP: begin
                dig_d[1] = SEG_O;
                dig_d[0] = SEG_P;
            end
            MODE_DASH: begin
                dig_d[3] = SEG_DASH;
                dig_d[2] = SEG_DASH;
                dig_d[1] = SEG_DASH;
                dig_d[0] = SEG_DASH;
            end
            default: begin
                dig_d[2] = SEG_E;
                dig_d[1] = SEG_R;
                dig_d[0] = SEG_R;
            end
        endcase
    end

    // Displayed-digit registers: hold the previous value until LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= SEG_BLANK;
            end
        end else if (load_en) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    // Free-running refresh divider and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= 2'd0;
        end else if (refresh_cnt_q == CNT_LAST) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= scan_idx_q + 2'd1;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
        end
    end

    // Anode and segment outputs registered together from the same index so
    // they always describe the same digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_select <= 4'b1110;
            disp_value  <= SEG_BLANK;
        end else begin
            disp_select <= ~(4'b0001 << scan_idx_q);
            disp_value  <= dig_q[scan_idx_q];
        end
    end

endmodule

// File: tb/tb_xseg_driver.sv
// Directed bench for xseg_driver with a short refresh divider.
module tb_xseg_driver;

    logic       clk;
    logic       rst;
    logic [3:0] disp_select;
    logic [7:0] disp_value;

    int n_checks;
    int n_fail;

    xseg_driver_if bus ();

    xseg_driver #(
        .REFRESH_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .disp_select (disp_select),
        .disp_value  (disp_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one write for a single cycle; returns just after the edge.
    task automatic write_bus(input logic [10:0] d);
        @(negedge clk);
        bus.sel     = 1'b1;
        bus.we      = 1'b1;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check_val(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    // Scan the display and pack {digit3, digit2, digit1, digit0}.
    task automatic capture(output logic [31:0] val);
        logic [3:0] seen;
        seen = 4'h0;
        val  = 32'h0;
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            @(negedge clk);
            case (disp_select)
                4'b1110: begin val[7:0]   = disp_value; seen[0] = 1'b1; end
                4'b1101: begin val[15:8]  = disp_value; seen[1] = 1'b1; end
                4'b1011: begin val[23:16] = disp_value; seen[2] = 1'b1; end
                4'b0111: begin val[31:24] = disp_value; seen[3] = 1'b1; end
                default: val = 32'h0;
            endcase
        end
    endtask

    task automatic write_and_show(input string tag, input logic [10:0] d, input logic [31:0] exp);
        logic [31:0] shown;
        write_bus(d);
        wait_idle({tag, "_idle"});
        capture(shown);
        check_val(tag, shown, exp);
    endtask

    initial begin
        logic [31:0] shown;
        int          busy_cycles;
        logic [3:0]  exp_sel;

        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
        bus.data_in = 11'd0;

        repeat (3) @(negedge clk);
        check_val("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check_val("rst_select", {28'd0, disp_select}, 32'h0000000E);
        check_val("rst_value",  {24'd0, disp_value}, 32'h000000FF);

        // Release on a falling edge; the next rising edge is scan edge 1.
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_sel = ~(4'b0001 << (((k - 1) / 4) % 4));
            check_val($sformatf("scan_sel_%0d", k), {28'd0, disp_select}, {28'd0, exp_sel});
            check_val($sformatf("scan_val_%0d", k), {24'd0, disp_value}, 32'h000000FF);
        end

        // 255: busy must last exactly 10 cycles after the accepting edge.
        write_bus(11'h0FF);
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        check_val("busy_len", busy_cycles, 32'd10);
        capture(shown);
        check_val("num_255", shown, 32'hFFA49292);

        write_and_show("num_neg7", 11'h107, 32'hBFFFFFF8);
        write_and_show("num_neg0", 11'h100, 32'hFFFFFFC0);
        write_and_show("msg_op",   11'h3FF, 32'hFFFFC08C);
        write_and_show("msg_dash", 11'h5AB, 32'hBFBFBFBF);

        // Err, then a second write three cycles later that must be dropped.
        write_bus(11'h600);
        repeat (2) @(posedge clk);
        check_val("err_busy_mid", {31'd0, bus.busy}, 32'd1);
        write_bus(11'h0FF);
        wait_idle("err_idle");
        capture(shown);
        check_val("msg_err", shown, 32'hFF86AFAF);
        repeat (3) @(negedge clk);
        check_val("err_no_restart", {31'd0, bus.busy}, 32'd0);

        // Write enable without select must not start a conversion.
        @(negedge clk);
        bus.sel     = 1'b0;
        bus.we      = 1'b1;
        bus.data_in = 11'h0FF;
        @(negedge clk);
        bus.we = 1'b0;
        check_val("nosel_busy", {31'd0, bus.busy}, 32'd0);
        capture(shown);
        check_val("nosel_disp", shown, 32'hFF86AFAF);

        // Reset during the conversion of 123.
        write_bus(11'h07B);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check_val("abort_select", {28'd0, disp_select}, 32'h0000000E);
        check_val("abort_value",  {24'd0, disp_value}, 32'h000000FF);
        @(negedge clk);
        rst = 1'b1;
        capture(shown);
        check_val("abort_blank", shown, 32'hFFFFFFFF);
        check_val("abort_idle", {31'd0, bus.busy}, 32'd0);

        write_and_show("num_45", 11'h02D, 32'hFFFF9992);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
